// File: rtl/disp_pkg.sv
// Shared display types, the blank code and the leading-zero blanking helper.
package disp_pkg;

    localparam logic [3:0]  BLANK_CODE = 4'hF;
    localparam int unsigned MAX_DIGITS = 8;
    localparam int unsigned MAX_W      = 4 * MAX_DIGITS;

    typedef enum logic {
        ST_BLANK,
        ST_SCAN
    } state_t;

    // Replace zero digits above the most significant nonzero digit with BLANK_CODE; digit 0 is kept.
    function automatic logic [MAX_W-1:0] lz_blank(input logic [MAX_W-1:0] digits,
                                                  input int unsigned       n);
        logic [MAX_W-1:0] res;
        logic             leading;
        res     = digits;
        leading = 1'b1;
        for (int unsigned i = MAX_DIGITS - 1; i >= 1; i--) begin
            if (i < n) begin
                if (leading && (digits[4*i +: 4] == 4'h0)) begin
                    res[4*i +: 4] = BLANK_CODE;
                end else begin
                    leading = 1'b0;
                end
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/scan_tick_gen.sv
// Digit-slot prescaler: counts 0..SCAN_DIV-1 and flags the terminal-count cycle.
module scan_tick_gen #(
    parameter int unsigned SCAN_DIV = 1000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    input  logic en,
    output logic tick_c
);

    localparam int unsigned CNT_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;

    logic [CNT_W-1:0] cnt_q;

    assign tick_c = en && (cnt_q == CNT_W'(SCAN_DIV - 1));

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else if (clr || tick_c) begin
            cnt_q <= '0;
        end else if (en) begin
            cnt_q <= cnt_q + CNT_W'(1);
        end
    end

endmodule

// File: rtl/bcd_display_scanner.sv
// Multiplexes NUM_DIGITS packed BCD digits onto a shared bcd bus with one-hot digit enables.
// Optional LEADING_ZERO_BLANK_EN blanks leading zero digits on the bcd output path.
module bcd_display_scanner
    import disp_pkg::*;
#(
    parameter int unsigned NUM_DIGITS = 4,
    parameter int unsigned SCAN_DIV   = 1000
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    load,
    input  logic [4*NUM_DIGITS-1:0] load_data,
    output logic                    ready,
    output logic [3:0]              bcd,
    output logic [NUM_DIGITS-1:0]   digit_en,
    output logic                    frame_done
);

    localparam int unsigned DW    = 4 * NUM_DIGITS;
    localparam int unsigned IDX_W = $clog2(NUM_DIGITS);

    state_t                state_q, state_n;
    logic [IDX_W-1:0]      idx_q, idx_n;
    logic [DW-1:0]         active_q, active_n;
    logic [DW-1:0]         pdata_q, pdata_n;
    logic                  pend_q, pend_n;
    logic [3:0]            bcd_n;
    logic [NUM_DIGITS-1:0] digit_en_n;
    logic                  frame_done_n;
    logic                  ready_n;
    logic                  transfer_c;
    logic                  tick_c;
    logic [MAX_W-1:0]      disp_c;

    scan_tick_gen #(
        .SCAN_DIV (SCAN_DIV)
    ) u_tick (
        .clk    (clk),
        .rst_n  (rst_n),
        .clr    (state_q == ST_BLANK),
        .en     (state_q == ST_SCAN),
        .tick_c (tick_c)
    );

    // Next-state and registered-output logic; bcd/digit_en are derived from the next idx/data.
    always_comb begin
        state_n      = state_q;
        idx_n        = idx_q;
        active_n     = active_q;
        pdata_n      = pdata_q;
        pend_n       = pend_q;
        frame_done_n = 1'b0;
        transfer_c   = load && ready;

        case (state_q)
            ST_BLANK: begin
                if (transfer_c) begin
                    state_n  = ST_SCAN;
                    active_n = load_data;
                    idx_n    = '0;
                end
            end
            ST_SCAN: begin
                if (tick_c) begin
                    if (idx_q == IDX_W'(NUM_DIGITS - 1)) begin
                        idx_n        = '0;
                        frame_done_n = 1'b1;
                        if (pend_q) begin
                            active_n = pdata_q;
                            pend_n   = 1'b0;
                        end
                    end else begin
                        idx_n = idx_q + IDX_W'(1);
                    end
                end
                // Only reachable with pend_q=0, so a same-cycle wrap never commits this data.
                if (transfer_c) begin
                    pdata_n = load_data;
                    pend_n  = 1'b1;
                end
            end
            default: state_n = ST_BLANK;
        endcase

`ifdef LEADING_ZERO_BLANK_EN
        disp_c = lz_blank(MAX_W'(active_n), NUM_DIGITS);
`else
        disp_c = MAX_W'(active_n);
`endif

        if (state_n == ST_SCAN) begin
            bcd_n      = disp_c[{idx_n, 2'b00} +: 4];
            digit_en_n = NUM_DIGITS'(1) << idx_n;
        end else begin
            bcd_n      = BLANK_CODE;
            digit_en_n = '0;
        end
        ready_n = !pend_n;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= ST_BLANK;
            idx_q      <= '0;
            active_q   <= '0;
            pdata_q    <= '0;
            pend_q     <= 1'b0;
            bcd        <= BLANK_CODE;
            digit_en   <= '0;
            frame_done <= 1'b0;
            ready      <= 1'b1;
        end else begin
            state_q    <= state_n;
            idx_q      <= idx_n;
            active_q   <= active_n;
            pdata_q    <= pdata_n;
            pend_q     <= pend_n;
            bcd        <= bcd_n;
            digit_en   <= digit_en_n;
            frame_done <= frame_done_n;
            ready      <= ready_n;
        end
    end

endmodule

// File: tb/tb_bcd_display_scanner.sv
// Self-checking bench for bcd_display_scanner against a frame-time reference model.
module tb_bcd_display_scanner;

    localparam int N = 4;
    localparam int D = 3;
    localparam int FRAME = N * D;

    logic          clk;
    logic          rst_n;
    logic          load;
    logic [15:0]   load_data;
    logic          ready;
    logic [3:0]    bcd;
    logic [N-1:0]  digit_en;
    logic          frame_done;

    int n_cmp = 0;
    int n_err = 0;

    // Reference model: display on/off, time within frame, committed and pending words.
    bit          m_on;
    int          m_t;
    logic [15:0] m_act;
    logic [15:0] m_pdata;
    bit          m_pend;
    bit          m_fd;

    bcd_display_scanner #(
        .NUM_DIGITS (N),
        .SCAN_DIV   (D)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .load       (load),
        .load_data  (load_data),
        .ready      (ready),
        .bcd        (bcd),
        .digit_en   (digit_en),
        .frame_done (frame_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at t=%0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [3:0] exp_digit(input logic [15:0] w, input int i);
        int top;
        top = 0;
        for (int k = 0; k < N; k++) begin
            if (w[4*k +: 4] != 4'h0) top = k;
        end
`ifdef LEADING_ZERO_BLANK_EN
        if (i > top) return 4'hF;
`endif
        return w[4*i +: 4];
    endfunction

    task automatic model_step(input logic r, input logic l, input logic [15:0] d);
        bit xfer;
        if (!r) begin
            m_on = 0; m_pend = 0; m_t = 0; m_fd = 0;
        end else if (!m_on) begin
            m_fd = 0;
            if (l) begin
                m_on = 1; m_act = d; m_t = 0;
            end
        end else begin
            xfer = l && !m_pend;
            m_t  = (m_t + 1) % FRAME;
            m_fd = (m_t == 0);
            if (m_fd && m_pend) begin
                m_act  = m_pdata;
                m_pend = 0;
            end
            if (xfer) begin
                m_pdata = d;
                m_pend  = 1;
            end
        end
    endtask

    task automatic cycle(input logic r, input logic l, input logic [15:0] d);
        @(negedge clk);
        rst_n = r; load = l; load_data = d;
        @(posedge clk);
        model_step(r, l, d);
        #1;
        check("bcd", 32'(bcd), m_on ? 32'(exp_digit(m_act, m_t / D)) : 32'hF);
        check("digit_en", 32'(digit_en), m_on ? 32'(4'(1) << (m_t / D)) : 32'h0);
        check("ready", 32'(ready), 32'(!m_pend));
        check("frame_done", 32'(frame_done), 32'(m_fd));
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cycle(1'b1, 1'b0, 16'h0);
    endtask

    task automatic align_to_wrap();
        int guard;
        guard = 0;
        while (m_t != FRAME - 1 && guard < 2 * FRAME) begin
            cycle(1'b1, 1'b0, 16'h0);
            guard++;
        end
    endtask

    initial begin
        logic [15:0] rd;
        rst_n = 1'b0; load = 1'b0; load_data = '0;
        m_on = 0; m_t = 0; m_act = '0; m_pdata = '0; m_pend = 0; m_fd = 0;

        // Reset, then a long idle period with the display dark.
        cycle(1'b0, 1'b0, 16'h0);
        cycle(1'b0, 1'b0, 16'h0);
        idle(20);

        // First load from BLANK, one full frame plus the wrap.
        cycle(1'b1, 1'b1, 16'h1234);
        idle(13);

        // Mid-frame load; a second load while not ready is ignored.
        idle(3);
        cycle(1'b1, 1'b1, 16'h5678);
        cycle(1'b1, 1'b1, 16'hDEAD);
        idle(24);

        // Load on the wrap edge: committed one frame later.
        align_to_wrap();
        cycle(1'b1, 1'b1, 16'h9ABC);
        idle(30);

        // Leading-zero patterns.
        cycle(1'b1, 1'b1, 16'h0090);
        idle(30);
        cycle(1'b1, 1'b1, 16'h0000);
        idle(30);
        cycle(1'b1, 1'b1, 16'h0F01);
        idle(30);

        // Reset with a load pending; the pending word must never show.
        idle(2);
        cycle(1'b1, 1'b1, 16'h4321);
        idle(2);
        cycle(1'b0, 1'b0, 16'h0);
        idle(10);
        cycle(1'b1, 1'b1, 16'h2468);
        idle(15);

        // Randomized traffic with sparse resets and zero-heavy digits.
        for (int i = 0; i < 1500; i++) begin
            for (int k = 0; k < N; k++) begin
                rd[4*k +: 4] = ($urandom_range(0, 1) == 0) ? 4'h0 : 4'($urandom_range(0, 15));
            end
            cycle(($urandom_range(0, 199) != 0), ($urandom_range(0, 7) == 0), rd);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
